// File: rtl/td_cpu_pkg.sv
// Shared types for the td_cpu core: opcode map, FSM states and opcode width.
package td_cpu_pkg;

  localparam int OPW = 4;

  typedef enum logic [OPW-1:0] {
    OP_ADD_AI = 4'b0000,
    OP_MOV_AB = 4'b0001,
    OP_IN_A   = 4'b0010,
    OP_MOV_AI = 4'b0011,
    OP_MOV_BA = 4'b0100,
    OP_ADD_BI = 4'b0101,
    OP_IN_B   = 4'b0110,
    OP_MOV_BI = 4'b0111,
    OP_ADD_AB = 4'b1000,
    OP_OUT_B  = 4'b1001,
    OP_OUT_I  = 4'b1011,
    OP_JZ     = 4'b1100,
    OP_HLT    = 4'b1101,
    OP_JNC    = 4'b1110,
    OP_JMP    = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_e;

endpackage

// File: rtl/td_cpu_alu.sv
// Combinational DW-bit adder producing sum, carry out and zero flag.
module td_cpu_alu #(
  parameter int DW = 4
) (
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] y,
  output logic [DW-1:0] sum,
  output logic          carry,
  output logic          zero
);

  assign {carry, sum} = {1'b0, x} + {1'b0, y};
  assign zero         = (sum == '0);

endmodule

// File: rtl/td_cpu_core.sv
// TD4-class CPU core: req/ack instruction fetch, one-cycle execute, stalled IN, strobed OUT.
// Handshakes: imem_req stays high with imem_addr stable until imem_ack; IN transfers on in_valid & in_ready.
module td_cpu_core
  import td_cpu_pkg::*;
#(
  parameter  int DW = 4,
  parameter  int AW = 4,
  localparam int IW = OPW + DW
) (
  input  logic          clk,
  input  logic          n_reset,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_data,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          halted,
  output state_e        dbg_state,
  output logic [AW-1:0] dbg_ip,
  output logic [DW-1:0] dbg_a,
  output logic [DW-1:0] dbg_b,
  output logic          dbg_cf,
  output logic          dbg_zf
);

  state_e        state;
  logic [DW-1:0] a, b;
  logic [AW-1:0] ip;
  logic [IW-1:0] ir;
  logic          cf, zf;

  opcode_e       op;
  logic [DW-1:0] imm;
  logic [AW-1:0] target;
  logic          is_in, stall;

  logic [DW-1:0] alu_x, alu_y, alu_sum;
  logic          alu_carry, alu_zero;

  assign op     = opcode_e'(ir[IW-1:DW]);
  assign imm    = ir[DW-1:0];
  assign target = imm[AW-1:0];
  assign is_in  = (op == OP_IN_A) || (op == OP_IN_B);
  assign stall  = in_ready && !in_valid;

  assign imem_req  = (state == FETCH);
  assign imem_addr = ip;
  assign in_ready  = (state == EXEC) && is_in;
  assign halted    = (state == HALT);

  assign dbg_state = state;
  assign dbg_ip    = ip;
  assign dbg_a     = a;
  assign dbg_b     = b;
  assign dbg_cf    = cf;
  assign dbg_zf    = zf;

  always_comb begin
    alu_x = a;
    alu_y = imm;
    case (op)
      OP_ADD_BI: alu_x = b;
      OP_ADD_AB: alu_y = b;
      default: ;
    endcase
  end

  td_cpu_alu #(.DW(DW)) u_alu (
    .x     (alu_x),
    .y     (alu_y),
    .sum   (alu_sum),
    .carry (alu_carry),
    .zero  (alu_zero)
  );

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state     <= FETCH;
      a         <= '0;
      b         <= '0;
      ip        <= '0;
      ir        <= '0;
      cf        <= 1'b0;
      zf        <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        FETCH: begin
          if (imem_ack) begin
            ir    <= imem_data;
            state <= EXEC;
          end
        end
        EXEC: begin
          // A stalled IN leaves every register untouched until in_valid arrives.
          if (!stall) begin
            state <= FETCH;
            ip    <= ip + AW'(1);
            cf    <= 1'b0;
            zf    <= 1'b0;
            case (op)
              OP_ADD_AI: begin a <= alu_sum; cf <= alu_carry; zf <= alu_zero; end
              OP_ADD_BI: begin b <= alu_sum; cf <= alu_carry; zf <= alu_zero; end
              OP_ADD_AB: begin a <= alu_sum; cf <= alu_carry; zf <= alu_zero; end
              OP_MOV_AI: a <= imm;
              OP_MOV_BI: b <= imm;
              OP_MOV_AB: a <= b;
              OP_MOV_BA: b <= a;
              OP_IN_A:   a <= in_data;
              OP_IN_B:   b <= in_data;
              OP_OUT_B:  begin out_data <= b;   out_valid <= 1'b1; end
              OP_OUT_I:  begin out_data <= imm; out_valid <= 1'b1; end
              OP_JMP:    ip <= target;
              OP_JNC:    if (!cf) ip <= target;
              OP_JZ:     if (zf)  ip <= target;
              OP_HLT:    state <= HALT;
              default: ;
            endcase
          end
        end
        HALT: ;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_td_cpu_core.sv
// Directed bench for td_cpu_core with a wait-stated ROM responder and immediate-assertion checks.
module tb_td_cpu_core;
  import td_cpu_pkg::*;

  localparam int DW = 4;
  localparam int AW = 4;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          n_reset;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [IW-1:0] imem_data;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          halted;
  state_e        dbg_state;
  logic [AW-1:0] dbg_ip;
  logic [DW-1:0] dbg_a, dbg_b;
  logic          dbg_cf, dbg_zf;

  logic [IW-1:0] rom [16];
  int            ack_delay;
  int            wait_cnt;
  int            out_pulses;
  int            errors = 0;
  int            checks = 0;

  td_cpu_core #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .halted    (halted),
    .dbg_state (dbg_state),
    .dbg_ip    (dbg_ip),
    .dbg_a     (dbg_a),
    .dbg_b     (dbg_b),
    .dbg_cf    (dbg_cf),
    .dbg_zf    (dbg_zf)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // ROM responder: acks after ack_delay wait cycles, drives junk data when not acking.
  initial begin
    imem_ack  = 1'b0;
    imem_data = '0;
    wait_cnt  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (imem_req && n_reset) begin
        if (wait_cnt >= ack_delay) begin
          imem_ack  = 1'b1;
          imem_data = rom[imem_addr];
          wait_cnt  = 0;
        end else begin
          imem_ack  = 1'b0;
          imem_data = IW'($urandom);
          wait_cnt++;
        end
      end else begin
        imem_ack  = 1'b0;
        imem_data = IW'($urandom);
        wait_cnt  = 0;
      end
    end
  end

  initial begin
    out_pulses = 0;
    forever begin
      @(negedge clk);
      if (out_valid) out_pulses++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'hA0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_reset = 1'b0;
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
  endtask

  // Runs n instructions; returns at the negedge after each execute edge.
  task automatic run_instr(input int n);
    for (int k = 0; k < n; k++) begin
      int cnt;
      cnt = 0;
      while (!(dbg_state == EXEC && !(in_ready && !in_valid)) && cnt < 100) begin
        @(negedge clk);
        cnt++;
      end
      if (cnt >= 100) begin
        checks++;
        errors++;
        $display("FAIL exec_timeout observed=%0d expected=<100", cnt);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    n_reset   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    ack_delay = 0;
    clear_rom();

    // Test 1: reset while a fetch is pending and ack withheld
    rom[0] = 8'hB7;  // OUT 7
    rom[1] = 8'h35;  // MOV A,5
    do_reset();
    check("rst_state", 32'(dbg_state), 32'(FETCH));
    check("rst_req", 32'(imem_req), 32'd1);
    run_instr(2);
    check("t1_a", 32'(dbg_a), 32'h5);
    check("t1_out", 32'(out_data), 32'h7);
    check("t1_ip", 32'(dbg_ip), 32'h2);
    ack_delay = 1000;
    n_reset   = 1'b0;
    @(negedge clk);
    check("t1_rst_ip", 32'(dbg_ip), 32'h0);
    check("t1_rst_addr", 32'(imem_addr), 32'h0);
    check("t1_rst_out", 32'(out_data), 32'h0);
    check("t1_rst_a", 32'(dbg_a), 32'h0);
    check("t1_rst_halted", 32'(halted), 32'h0);
    check("t1_rst_state", 32'(dbg_state), 32'(FETCH));
    check("t1_rst_outv", 32'(out_valid), 32'h0);
    ack_delay = 0;

    // Test 2: MOV A,3; ADD A,15; JNC 0 (not taken)
    clear_rom();
    rom[0] = 8'h33;
    rom[1] = 8'h0F;
    rom[2] = 8'hE0;
    do_reset();
    run_instr(2);
    check("t2_a", 32'(dbg_a), 32'h2);
    check("t2_cf", 32'(dbg_cf), 32'h1);
    check("t2_zf", 32'(dbg_zf), 32'h0);
    run_instr(1);
    check("t2_jnc_addr", 32'(imem_addr), 32'h3);
    check("t2_cf_clr", 32'(dbg_cf), 32'h0);

    // Test 3: MOV A,1; MOV B,15; ADD A,B; JZ 9
    clear_rom();
    rom[0] = 8'h31;
    rom[1] = 8'h7F;
    rom[2] = 8'h80;
    rom[3] = 8'hC9;
    do_reset();
    run_instr(3);
    check("t3_a", 32'(dbg_a), 32'h0);
    check("t3_b", 32'(dbg_b), 32'hF);
    check("t3_cf", 32'(dbg_cf), 32'h1);
    check("t3_zf", 32'(dbg_zf), 32'h1);
    run_instr(1);
    check("t3_jz_addr", 32'(imem_addr), 32'h9);
    check("t3_zf_clr", 32'(dbg_zf), 32'h0);

    // Test 4: three wait states on every fetch
    clear_rom();
    rom[0] = 8'h76;  // MOV B,6
    rom[1] = 8'h53;  // ADD B,3
    ack_delay = 3;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_wait_req", 32'(imem_req), 32'h1);
      check("t4_wait_addr", 32'(imem_addr), 32'h0);
      check("t4_wait_b", 32'(dbg_b), 32'h0);
    end
    run_instr(1);
    check("t4_b6", 32'(dbg_b), 32'h6);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_wait2_req", 32'(imem_req), 32'h1);
      check("t4_wait2_addr", 32'(imem_addr), 32'h1);
      check("t4_wait2_b", 32'(dbg_b), 32'h6);
    end
    run_instr(1);
    check("t4_b9", 32'(dbg_b), 32'h9);
    check("t4_ip", 32'(dbg_ip), 32'h2);
    ack_delay = 0;

    // Test 5: IN A stalled for 4 cycles
    clear_rom();
    rom[0] = 8'h20;  // IN A
    do_reset();
    check("t5_ready_fetch", 32'(in_ready), 32'h0);
    begin
      int cnt, ready_cnt;
      cnt = 0;
      ready_cnt = 0;
      while (dbg_state != EXEC && cnt < 20) begin
        @(negedge clk);
        cnt++;
      end
      check("t5_reach_exec", 32'(dbg_state), 32'(EXEC));
      for (int i = 0; i < 4; i++) begin
        if (in_ready) ready_cnt++;
        check("t5_stall_ip", 32'(dbg_ip), 32'h0);
        check("t5_stall_a", 32'(dbg_a), 32'h0);
        @(negedge clk);
      end
      if (in_ready) ready_cnt++;
      check("t5_ready_cycles", 32'(ready_cnt), 32'd5);
      in_data  = 4'hA;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 4'h3;
      check("t5_a", 32'(dbg_a), 32'hA);
      check("t5_ip", 32'(dbg_ip), 32'h1);
      check("t5_ready_low", 32'(in_ready), 32'h0);
      run_instr(1);
      check("t5_one_xfer_a", 32'(dbg_a), 32'hA);
      check("t5_ip2", 32'(dbg_ip), 32'h2);
    end

    // Test 6: OUT imm, OUT B, JMP 15, wrap, HLT
    clear_rom();
    rom[0]  = 8'h7C;  // MOV B,12
    rom[1]  = 8'hB5;  // OUT 5
    rom[2]  = 8'h90;  // OUT B
    rom[3]  = 8'hFF;  // JMP 15
    rom[15] = 8'hA0;  // NOP
    do_reset();
    out_pulses = 0;
    run_instr(1);
    rom[0] = 8'hD0;   // HLT once the wrap returns to 0
    run_instr(1);
    check("t6_out5_v", 32'(out_valid), 32'h1);
    check("t6_out5_d", 32'(out_data), 32'h5);
    @(negedge clk);
    check("t6_out5_v_off", 32'(out_valid), 32'h0);
    check("t6_out5_hold", 32'(out_data), 32'h5);
    run_instr(1);
    check("t6_outb_v", 32'(out_valid), 32'h1);
    check("t6_outb_d", 32'(out_data), 32'hC);
    @(negedge clk);
    check("t6_outb_v_off", 32'(out_valid), 32'h0);
    run_instr(1);
    check("t6_jmp_ip", 32'(dbg_ip), 32'hF);
    run_instr(1);
    check("t6_wrap_ip", 32'(dbg_ip), 32'h0);
    run_instr(1);
    check("t6_halted", 32'(halted), 32'h1);
    check("t6_state", 32'(dbg_state), 32'(HALT));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t6_halt_req", 32'(imem_req), 32'h0);
    end
    check("t6_halt_keep", 32'(halted), 32'h1);
    check("t6_out_pulses", 32'(out_pulses), 32'd2);
    check("t6_out_final", 32'(out_data), 32'hC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/td_cpu_core.md
Name: td_cpu_core

Overview:
Parametrised successor to the 4-bit TD4-class CPU core, with generic data/address width and a multi-cycle fetch/execute FSM.
- Instruction fetch uses a req/ack handshake, so wait-stated ROM/RAM can be attached.
- Input is valid/ready stalled; output is a registered value plus a one-cycle strobe.
- Adds A+B, a zero flag, JZ and HLT, and keeps the legacy opcode encodings.
- Sits on the mother board between the program memory and the switch/LED I/O.

Parameters:
DW, 4, data/register width; immediate width; must satisfy DW >= AW
AW, 4, instruction address width; IP wraps modulo 2^AW
IW, 4+DW (localparam), instruction word width: [IW-1:DW] opcode, [DW-1:0] imm

Ports:
clk  in  1  clock
n_reset  in  1  reset
imem_req  out  1  fetch request, held until ack
imem_addr  out  AW  fetch address (= ip), stable while req high
imem_ack  in  1  fetch complete; imem_data valid this cycle
imem_data  in  IW  instruction word
in_data  in  DW  input port data
in_valid  in  1  input data valid
in_ready  out  1  core waiting on IN instruction
out_data  out  DW  output port register (LED)
out_valid  out  1  one-cycle strobe: out_data updated
halted  out  1  core in HALT state

Behaviour:
- Reset: n_reset is synchronous, active-low, on clk. On reset: a=b=0, cf=zf=0, ip=0, ir=0, out_data=0, out_valid=0, state=FETCH. Reset overrides any pending fetch or IN wait.
- FSM states: FETCH, EXEC, HALT.
- FETCH:
  - imem_req=1, imem_addr=ip.
  - On imem_ack: ir<=imem_data, go to EXEC.
  - Same-cycle ack is legal, giving a 1-cycle fetch.
- EXEC:
  - Executes ir in one cycle, then returns to FETCH. IN stalls; HLT goes to HALT.
  - Default next_ip = ip+1 (mod 2^AW).
- HALT: terminal. imem_req=0, halted=1. Only reset leaves it.
- Opcodes (ir[IW-1:DW]); imm = ir[DW-1:0]; jump target = imm[AW-1:0]:
  - 0000 ADD A,imm: {cf,a} = a+imm
  - 0101 ADD B,imm: {cf,b} = b+imm
  - 1000 ADD A,B: {cf,a} = a+b
  - 0011 MOV A,imm; 0111 MOV B,imm
  - 0001 MOV A,B; 0100 MOV B,A
  - 0010 IN A; 0110 IN B
  - 1001 OUT B; 1011 OUT imm
  - 1111 JMP imm
  - 1110 JNC imm: jump if cf==0
  - 1100 JZ imm: jump if zf==1
  - 1101 HLT
  - all others: NOP
- Flags:
  - ADD instructions set cf to the carry out of the DW-bit add, and zf to (DW-bit result == 0).
  - Every other executed instruction, including NOP, jumps, IN and OUT, clears cf and zf (legacy cf semantics, extended to zf).
  - JNC/JZ test the flags as they were before the current instruction.
- IN:
  - in_ready=1 only in EXEC with an IN opcode.
  - Transfer occurs when in_valid & in_ready; the register loads in_data, then FETCH.
  - With in_valid low, the core stays in EXEC: ip, flags and registers unchanged, in_ready held high.
- OUT:
  - out_data<=value at the EXEC edge; out_valid=1 in the following cycle only.
  - out_data holds until the next OUT or reset.
- Throughput: 2 cycles per instruction minimum (zero-wait ack, no IN stall).
- Boundaries:
  - ip=2^AW-1 with a non-jump instruction wraps to 0.
  - imem_ack outside FETCH is ignored.
  - imem_data is sampled only on ack.
  - Flag and register updates occur only in EXEC.

Decomposition:
- Package td_cpu_pkg holds:
  - opcode_e, a 4-bit enum using the encodings above;
  - state_e {FETCH, EXEC, HALT};
  - localparam OPW=4.
- One combinational sub-module, td_cpu_alu, computes the DW-bit sum, carry and zero flag; the core instantiates it once.
- The FSM, decode and registers stay in td_cpu_core.

Test Plan (DW=4, AW=4):
1. Assert reset while imem_req is high and ack is withheld -> next cycle ip=0, imem_addr=0, out_data=0, halted=0, state FETCH.
2. Program MOV A,3; ADD A,15; JNC 0 -> a=2, cf=1 after the ADD; JNC not taken, so next imem_addr=3.
3. Program MOV A,1; MOV B,15; ADD A,B; JZ 9 -> a=0, cf=1, zf=1; next fetch address=9.
4. Delay imem_ack 3 cycles on every fetch -> imem_req and imem_addr stable during the wait; register state unchanged until ack.
5. IN A with in_valid low for 4 cycles, then in_data=0xA with in_valid high -> in_ready high for 5 cycles, a=0xA, exactly one transfer, ip advanced once.
6. OUT imm 5; OUT B (b=0xC); JMP 15; a NOP at address 15 -> out_data=5 then 0xC, each with a single out_valid pulse; ip wraps 15->0. Then HLT -> halted=1 and imem_req stays 0 permanently.
